// File: rtl/uart_pkg.sv
// uart_pkg: UART state encoding, oversample ratio and default frame parameters shared by tx and rx
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam int OVERSAMPLE = 16;
    localparam int DEF_DATA_BIT = 8;
    localparam int DEF_SB_TICK = 16;
endpackage

// File: rtl/uart_tx_core.sv
// uart_tx_core: UART transmitter (clk, async rst, s_tick 16x baud tick, tx_start/din request; tx line, tx_ready in idle, tx_done_tick at end of stop)
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int DATA_BIT   = DEF_DATA_BIT,
    parameter int SB_TICK    = DEF_SB_TICK,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_tick,
    input  logic                tx_start,
    input  logic [DATA_BIT-1:0] din,
    output logic                tx,
    output logic                tx_ready,
    output logic                tx_done_tick
);
    localparam logic [4:0] TICK_LAST = 5'(OVERSAMPLE - 1);
    localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [2:0] BIT_LAST  = 3'(DATA_BIT - 1);
    state_t state, state_n;
    logic [4:0] s, s_n;
    logic [2:0] n, n_n;
    logic [DATA_BIT-1:0] b, b_n;
    logic par, par_n, tx_n, done_n;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            b            <= '0;
            par          <= 1'b0;
            tx           <= 1'b1;
            tx_done_tick <= 1'b0;
        end else begin
            state        <= state_n;
            s            <= s_n;
            n            <= n_n;
            b            <= b_n;
            par          <= par_n;
            tx           <= tx_n;
            tx_done_tick <= done_n;
        end
    end
    assign tx_ready = (state == IDLE);
    always_comb begin
        state_n = state;
        s_n     = s;
        n_n     = n;
        b_n     = b;
        par_n   = par;
        done_n  = 1'b0;
        case (state)
            IDLE: if (tx_start) begin
                state_n = START;
                s_n     = '0;
                n_n     = '0;
                b_n     = din;
                par_n   = (PARITY_ODD != 0);
            end
            START: if (s_tick) begin
                s_n     = (s == TICK_LAST) ? 5'd0 : s + 5'd1;
                state_n = (s == TICK_LAST) ? DATA : START;
            end
            DATA: if (s_tick) begin
                s_n = (s == TICK_LAST) ? 5'd0 : s + 5'd1;
                if (s == TICK_LAST) begin
                    // parity accumulates from the latched bits as they leave the shifter
                    b_n   = b >> 1;
                    par_n = par ^ b[0];
                    n_n   = n + 3'd1;
                    if (n == BIT_LAST) state_n = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: if (s_tick) begin
                s_n     = (s == TICK_LAST) ? 5'd0 : s + 5'd1;
                state_n = (s == TICK_LAST) ? STOP : PARITY;
            end
            STOP: if (s_tick) begin
                s_n     = (s == STOP_LAST) ? 5'd0 : s + 5'd1;
                state_n = (s == STOP_LAST) ? IDLE : STOP;
                done_n  = (s == STOP_LAST);
            end
            default: state_n = IDLE;
        endcase
        // tx is registered: drive the level belonging to the state being entered
        tx_n = (state_n == START) ? 1'b0 :
               (state_n == DATA) ? b_n[0] :
               (state_n == PARITY) ? par_n : 1'b1;
    end
endmodule

// File: doc/uart_tx_core.md
UART_TX_CORE -- requirements
Module: uart_tx_core

Interface
REQ-001 The block SHALL have parameter DATA_BIT, default 8, giving the data bits per frame; legal range is 5..8.
REQ-002 The block SHALL have parameter SB_TICK, default 16, giving the s_tick count for the stop period; legal values are 16, 24 and 32 (1, 1.5 and 2 stop bits).
REQ-003 The block SHALL have parameter PARITY_EN, default 0; when 1, a parity bit is inserted after the data bits.
REQ-004 The block SHALL have parameter PARITY_ODD, default 0; 0 selects even parity and 1 selects odd parity.
REQ-005 The block SHALL use reset rst, asynchronous, active-high, and clock clk.
REQ-006 The block SHALL have these ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
s_tick  in  1  16x-oversample baud tick, one clk wide
tx_start  in  1  request to send din
din  in  DATA_BIT  parallel data to transmit
tx  out  1  serial line, idle high, registered
tx_ready  out  1  high in IDLE; tx_start is accepted only while this is high
tx_done_tick  out  1  one-clk pulse at the end of the stop period

Function
REQ-007 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP; PARITY is reachable only when PARITY_EN=1.
REQ-008 In IDLE, tx SHALL be 1 and tx_ready SHALL be 1.
REQ-009 When tx_start=1 and tx_ready=1, the block SHALL latch din into the shift register, clear the tick and bit counters, and enter START; tx SHALL be 0 from the next clk edge.
REQ-010 Each of START, DATA bits and PARITY SHALL last exactly 16 s_ticks, counted by a 5-bit tick counter that compares against 15 and then clears.
REQ-011 An s_tick in the same cycle as acceptance SHALL NOT be counted.
REQ-012 In DATA, the block SHALL send bits LSB first: tx = shift_reg[0], shifting right at each bit boundary, with the bit counter running 0..DATA_BIT-1.
REQ-013 The block SHALL leave DATA after bit DATA_BIT-1 at tick 15, going to PARITY if PARITY_EN=1 and otherwise to STOP.
REQ-014 In PARITY, tx SHALL equal the XOR of the latched data bits, inverted when PARITY_ODD=1; parity SHALL be computed from the latched copy, never from live din.
REQ-015 In STOP, tx SHALL be 1; at tick count SB_TICK-1 with s_tick, the block SHALL pulse tx_done_tick for one clk and return to IDLE.
REQ-016 tx_start SHALL be ignored while tx_ready=0, with no queuing.
REQ-017 Changes on din after acceptance SHALL NOT affect the frame in progress.
REQ-018 Back-to-back frames: tx_start asserted in the cycle after tx_done_tick SHALL be accepted; the stop bit plus the next start edge SHALL introduce no extra idle ticks beyond one clk.
REQ-019 Total frame length SHALL be 16*(1+DATA_BIT+PARITY_EN) + SB_TICK s_ticks.
REQ-020 Without s_tick, the block SHALL hold its state and tx indefinitely.

Reset
REQ-021 While rst=1, the block SHALL force state IDLE, tx=1, tx_ready=1, tx_done_tick=0, and clear the counters and shift register, asynchronously.
REQ-022 Reset mid-frame SHALL abort the frame: tx returns high immediately and no tx_done_tick is produced.
REQ-023 After rst deasserts, the first accepted tx_start SHALL produce a complete, correct frame.

Structure
REQ-024 Package uart_pkg SHALL hold the state encoding, OVERSAMPLE=16, and the default DATA_BIT and SB_TICK values shared with the receiver.
REQ-025 The block SHALL be a single module with no sub-module; parity is a reduction XOR inline.

Verification
REQ-026 Test 0xA5 in 8N1: tx_start with din=8'hA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1 at 16 ticks each; tx_done_tick after the 160th tick.
REQ-027 Test 0x07 with PARITY_EN=1 (8E1): parity bit=1; with PARITY_ODD=1 the parity bit=0; frame is 176 ticks.
REQ-028 Test ignore-while-busy: pulse tx_start with din=8'h3C at data bit 3 of an 8'h55 frame -> the 8'h55 frame completes unchanged and no second frame is sent.
REQ-029 Test reset mid-frame: rst during data bit 4 -> tx=1 the same cycle, no done pulse; the next 8'h81 frame is correct.
REQ-030 Test back-to-back with SB_TICK=32: 8'h00 then 8'hFF with tx_start in the cycle after done -> stop high for exactly 32 ticks, then an immediate start bit.
